stream_demux1t4_32: RTL and testbench
=====================================

// Module: stream_demux1t4_32
// PURPOSE
//  Routes one 32-bit valid/ready input stream to one of four output streams, selected per word by s_sel.
//  It is the distributing counterpart of the 4:1 32-bit selector: one producer feeds four consumers.
//  Each output port has its own 2-entry FIFO, so a stalled consumer blocks only words addressed to it.
//  Per-port delivered-word counters support datapath debug and bench scoreboarding.
// PARAMETERS
//  WIDTH   32  data width of the input and of every output
//  CNT_W   16  width of each per-port delivered-word counter
// PORTS
//  clk        in   1        single clock; all state updates on the rising edge
//  rst_n      in   1        asynchronous active-low reset
//  s_valid    in   1        input word valid
//  s_ready    out  1        input word accepted when s_valid & s_ready
//  s_sel      in   2        destination port 0..3 for the current input word
//  s_data     in   WIDTH    input word
//  m_valid    out  4        per-port output valid; bit i belongs to port i
//  m_ready    in   4        per-port consumer ready
//  m_data0    out  WIDTH    port 0 head word (m_data1..m_data3 are identical for ports 1..3)
//  cnt_clr    in   1        synchronous clear of all four counters
//  cnt0..cnt3 out  CNT_W    per-port delivered-word count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all FIFOs empty, m_valid=4'b0000, all m_dataN=0, all cntN=0.
//    s_ready is 1 after reset, because every FIFO is empty.
//  - s_ready = ~full[s_sel], combinational in s_sel and registered occupancy.
//    It does not depend on s_valid or m_ready; a full FIFO never accepts, even if its pop is in the same cycle.
//  - Push: when s_valid & s_ready, s_data is written into FIFO[s_sel] at the edge.
//    The word is visible on m_data[s_sel] with m_valid=1 on the next cycle if that FIFO was empty (latency 1).
//  - Pop: when m_valid[i] & m_ready[i], the head of FIFO i is removed at the edge.
//    cnt_i increments by 1, wrapping from 2^CNT_W-1 to 0. All four ports may pop in the same cycle.
//  - Push and pop on the same port in the same cycle: occupancy is unchanged and FIFO order is preserved.
//    With 1 entry, the pushed word becomes the head after the pop.
//  - Ordering is guaranteed within each port only; there is no ordering relation across ports.
//  - m_dataN holds its last head value while m_valid[N]=0. It changes only on a push to an empty FIFO or on a pop.
//  - Occupancy per port is 0, 1 or 2; full = (occ==2), empty = (occ==0). Pointers are 1 bit and wrap 1->0.
//  - cnt_clr: all counters become 0 at the edge. cnt_clr has priority over a same-cycle increment.
//  - The master must hold s_valid, s_sel and s_data stable until accepted.
//    A change of s_sel while s_valid=1 and s_ready=0 is a protocol error; the block does not check it.
//  - Asserting rst_n low mid-stream discards all buffered words immediately; nothing is replayed.
// STRUCTURE
//  - Shared package demux_pkg: NPORTS=4, SEL_W=2, FIFO_DEPTH=2, and the occupancy encoding constants.
//  - Sub-module demux_slot_fifo (WIDTH): 2-entry FIFO with push/pop, full/empty/valid and head data.
//    It is instantiated 4 times; push_i = s_valid & s_ready & (s_sel==i).
//  - Top level: select decode, s_ready multiplexing, and the four counters.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs.
//     -> m_valid=0000, s_ready=1, cnt0..3=0, m_data0..3=0.
//  2. Route: send 0xA0000000..0xA0000003 with s_sel=0..3, m_ready=1111.
//     -> each word appears on its port one cycle after acceptance; cnt0..3=1.
//  3. Backpressure: m_ready[2]=0; send three words to port 2, then a word to port 1.
//     -> first two accepted, s_ready=0 on the third; s_ready returns to 1 once s_sel is switched to 1.
//  4. Simultaneous push/pop: port 0 holds 1 entry and m_ready[0]=1 while pushing 0x55.
//     -> occupancy stays 1 and the next head is 0x55.
//  5. Counter: preload cnt3 to 0xFFFF with 65535 pops, then one more pop with cnt_clr=0.
//     -> cnt3=0x0000. A pop in the same cycle as cnt_clr=1 -> cnt3=0.
//  6. Async reset mid-stream: drop rst_n between clock edges with 2 words buffered on port 1.
//     -> m_valid[1]=0 at once, with no clock edge required.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 stream demultiplexer: port count, select width,
// per-port FIFO depth and the occupancy encoding.
package demux_pkg;

    localparam int NPORTS     = 4;
    localparam int SEL_W      = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/demux_slot_fifo.sv
// Two-entry ring-buffer FIFO for one demux output port. The head word is always
// presented on head; it only moves on a push into an empty FIFO or on a pop.
module demux_slot_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    occ_e             occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == OCC_EMPTY);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= OCC_EMPTY;
            // NOTE: the storage is reset on purpose: head is visible even when empty and
            // must read zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
                2'b01:   occ <= (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux1t4_32.sv
// Routes one valid/ready input stream to one of four buffered output ports chosen
// per word by s_sel, with a delivered-word counter on each port.
module stream_demux1t4_32
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SEL_W-1:0]   s_sel,
    input  logic [WIDTH-1:0]   s_data,
    output logic [NPORTS-1:0]  m_valid,
    input  logic [NPORTS-1:0]  m_ready,
    output logic [WIDTH-1:0]   m_data0,
    output logic [WIDTH-1:0]   m_data1,
    output logic [WIDTH-1:0]   m_data2,
    output logic [WIDTH-1:0]   m_data3,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   cnt0,
    output logic [CNT_W-1:0]   cnt1,
    output logic [CNT_W-1:0]   cnt2,
    output logic [CNT_W-1:0]   cnt3
);

    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [WIDTH-1:0]  head [NPORTS];
    logic [CNT_W-1:0]  cnt  [NPORTS];

    // A full slot refuses a push even if it is popped in the same cycle.
    assign s_ready = ~full[s_sel];
    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;

    always_comb begin
        // NOTE: default every combinational output before any conditional write,
        // otherwise the untaken paths infer latches.
        push = '0;
        if (s_valid && s_ready) begin
            push[s_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        demux_slot_fifo #(.WIDTH(WIDTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (s_data),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // Clear wins over a same-cycle delivery; counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NPORTS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (pop[i]) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign m_data0 = head[0];
    assign m_data1 = head[1];
    assign m_data2 = head[2];
    assign m_data3 = head[3];
    assign cnt0    = cnt[0];
    assign cnt1    = cnt[1];
    assign cnt2    = cnt[2];
    assign cnt3    = cnt[3];

endmodule

// File: tb/tb_stream_demux1t4_32.sv
// Self-checking bench for stream_demux1t4_32: directed scenarios plus random traffic,
// scored against per-port word queues and modulo-2^16 delivery counts.
module tb_stream_demux1t4_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_sel;
    logic [31:0] s_data;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [31:0] m_data0, m_data1, m_data2, m_data3;
    logic        cnt_clr;
    logic [15:0] cnt0, cnt1, cnt2, cnt3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq [4][$];
    int          mcnt [4];
    logic        last_acc = 1'b0;

    always #5 clk = ~clk;

    stream_demux1t4_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sel   (s_sel),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data0 (m_data0),
        .m_data1 (m_data1),
        .m_data2 (m_data2),
        .m_data3 (m_data3),
        .cnt_clr (cnt_clr),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .cnt3    (cnt3)
    );

    function automatic logic [31:0] data_of(input int p);
        case (p)
            0:       return m_data0;
            1:       return m_data1;
            2:       return m_data2;
            default: return m_data3;
        endcase
    endfunction

    function automatic logic [15:0] cnt_of(input int p);
        case (p)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
    endfunction

    // Advance one clock with the currently driven inputs, update the model and
    // compare every observable output against it at the following falling edge.
    task automatic step(input string tag);
        logic       exp_rdy;
        logic       acc;
        logic [3:0] pops;
        logic [3:0] exp_v;
        #1;
        exp_rdy = (mq[s_sel].size() < 2);
        checks++;
        if (s_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s s_ready got=%b exp=%b", tag, s_ready, exp_rdy);
        end
        acc = s_valid && exp_rdy;
        for (int i = 0; i < 4; i++) pops[i] = m_ready[i] && (mq[i].size() > 0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) begin
                mq[i].delete(0);
                mcnt[i] = (mcnt[i] + 1) % 65536;
            end
        end
        if (cnt_clr) for (int i = 0; i < 4; i++) mcnt[i] = 0;
        if (acc) mq[s_sel].push_back(s_data);
        last_acc = acc;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_v[i] = (mq[i].size() > 0);
        checks++;
        if (m_valid !== exp_v) begin
            failures++;
            $display("FAIL %s m_valid got=%b exp=%b", tag, m_valid, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0) begin
                checks++;
                if (data_of(i) !== mq[i][0]) begin
                    failures++;
                    $display("FAIL %s m_data%0d got=%h exp=%h", tag, i, data_of(i), mq[i][0]);
                end
            end
            checks++;
            if (cnt_of(i) !== 16'(mcnt[i])) begin
                failures++;
                $display("FAIL %s cnt%0d got=%h exp=%h", tag, i, cnt_of(i), 16'(mcnt[i]));
            end
        end
    endtask

    task automatic idle(input logic [3:0] rdy);
        s_valid = 1'b0;
        cnt_clr = 1'b0;
        m_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            s_valid = 1'($urandom);
            s_sel   = 2'($urandom);
            s_data  = $urandom;
            m_ready = 4'($urandom);
            cnt_clr = 1'($urandom);
            @(negedge clk);
            #1;
            checks++;
            if (m_valid !== 4'b0000 || s_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset valid/ready got=%b/%b exp=0000/1", m_valid, s_ready);
            end
            checks++;
            if ({m_data0, m_data1, m_data2, m_data3} !== 128'd0) begin
                failures++;
                $display("FAIL reset m_data got=%h %h %h %h exp=0", m_data0, m_data1, m_data2, m_data3);
            end
            checks++;
            if ({cnt0, cnt1, cnt2, cnt3} !== 64'd0) begin
                failures++;
                $display("FAIL reset cnt got=%h %h %h %h exp=0", cnt0, cnt1, cnt2, cnt3);
            end
        end
        idle(4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step("reset_idle");
    endtask

    task automatic test_route();
        idle(4'b1111);
        cnt_clr = 1'b1;
        step("route_clr");
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_sel   = 2'(i);
            s_data  = 32'hA000_0000 + 32'(i);
            step("route");
            checks++;
            if (m_valid[i] !== 1'b1 || data_of(i) !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL route port%0d valid=%b data=%h exp valid=1 data=%h",
                         i, m_valid[i], data_of(i), 32'hA000_0000 + 32'(i));
            end
        end
        idle(4'b1111);
        step("route_drain");
        checks++;
        if ({cnt0, cnt1, cnt2, cnt3} !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
            failures++;
            $display("FAIL route counts got=%h %h %h %h exp=1 1 1 1", cnt0, cnt1, cnt2, cnt3);
        end
    endtask

    task automatic test_backpressure();
        idle(4'b1011);
        s_valid = 1'b1;
        s_sel   = 2'd2;
        for (int n = 0; n < 2; n++) begin
            s_data = 32'hB200_0000 + 32'(n);
            step("bp_fill");
            checks++;
            if (last_acc !== 1'b1) begin
                failures++;
                $display("FAIL bp_fill word%0d not accepted by model exp=accepted", n);
            end
        end
        s_data = 32'hB200_0002;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full s_ready got=%b exp=0", s_ready);
        end
        step("bp_stall");
        s_sel  = 2'd1;
        s_data = 32'hB100_0000;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_switch s_ready got=%b exp=1", s_ready);
        end
        step("bp_port1");
        idle(4'b1111);
        for (int n = 0; n < 3; n++) step("bp_drain");
    endtask

    task automatic test_push_pop();
        idle(4'b1110);
        s_valid = 1'b1;
        s_sel   = 2'd0;
        s_data  = 32'h0000_0011;
        step("pp_load");
        m_ready = 4'b1111;
        s_data  = 32'h0000_0055;
        step("pp_same");
        checks++;
        if (m_valid[0] !== 1'b1 || m_data0 !== 32'h0000_0055 || mq[0].size() != 1) begin
            failures++;
            $display("FAIL push_pop valid=%b data=%h exp valid=1 data=00000055", m_valid[0], m_data0);
        end
        idle(4'b1111);
        step("pp_drain");
        checks++;
        if (m_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_drain valid=%b exp=0", m_valid[0]);
        end
    endtask

    task automatic test_counter();
        int guard = 0;
        idle(4'b1111);
        cnt_clr = 1'b1;
        step("cnt_clr");
        cnt_clr = 1'b0;
        s_valid = 1'b1;
        s_sel   = 2'd3;
        while (mcnt[3] != 65535 && guard < 70000) begin
            s_data = $urandom;
            step("cnt_fill");
            guard++;
        end
        checks++;
        if (guard >= 70000) begin
            failures++;
            $display("FAIL cnt_fill budget expired cnt3=%h exp=ffff", cnt3);
        end
        s_valid = 1'b0;
        step("cnt_wrap");
        checks++;
        if (cnt3 !== 16'h0000) begin
            failures++;
            $display("FAIL cnt_wrap cnt3 got=%h exp=0000", cnt3);
        end
        s_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            s_data = $urandom;
            step("cnt_more");
        end
        checks++;
        if (cnt3 === 16'h0000 || m_valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL cnt_more cnt3=%h valid3=%b exp nonzero/1", cnt3, m_valid[3]);
        end
        s_valid = 1'b0;
        cnt_clr = 1'b1;
        step("cnt_clr_pop");
        checks++;
        if (cnt3 !== 16'h0000) begin
            failures++;
            $display("FAIL cnt_clr_pop cnt3 got=%h exp=0000", cnt3);
        end
        idle(4'b1111);
        for (int n = 0; n < 2; n++) step("cnt_drain");
    endtask

    task automatic test_async_reset();
        idle(4'b1101);
        s_valid = 1'b1;
        s_sel   = 2'd1;
        for (int n = 0; n < 2; n++) begin
            s_data = 32'hC100_0000 + 32'(n);
            step("ar_fill");
        end
        s_valid = 1'b0;
        #2;
        checks++;
        if (m_valid[1] !== 1'b1) begin
            failures++;
            $display("FAIL async_pre valid1 got=%b exp=1", m_valid[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 4'b0000 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_rst valid=%b ready=%b exp=0000/1", m_valid, s_ready);
        end
        checks++;
        if (m_data1 !== 32'd0 || cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL async_rst data1=%h cnt1=%h exp=0/0", m_data1, cnt1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(4'b1111);
        step("ar_after");
    endtask

    task automatic test_random();
        idle(4'b0000);
        last_acc = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!(s_valid && !last_acc)) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_sel   = 2'($urandom);
                s_data  = $urandom;
            end
            m_ready = 4'($urandom);
            cnt_clr = ($urandom_range(0, 63) == 0);
            step("random");
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sel   = '0;
        s_data  = '0;
        m_ready = '0;
        cnt_clr = 1'b0;
        model_reset();
        test_reset();
        test_route();
        test_backpressure();
        test_push_pop();
        test_random();
        test_counter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
